vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port GPU video RAM (tile map, attribute/font and colour regions in one address space)
//  between the pixel fetch pipeline and the CPU bus interface. Sits between pixel generator / CPU bus bridge
//  and the VRAM macro. Pixel fetches win during active video; the CPU wins during blanking. A starvation
//  counter guarantees the CPU a slot during long active periods.
// PARAMETERS
//  ADDR_W        13  VRAM address width (bytes)
//  DATA_W         8  VRAM data width
//  STARVE_LIMIT   8  consecutive cycles a CPU request may lose before it is forced through (1..255)
// PORTS
//  clk          in   1       system clock (4x pixel clock)
//  rst          in   1       asynchronous, active-low reset
//  vga_blank    in   1       1 = horizontal/vertical blanking; selects CPU priority
//  pix_req      in   1       pixel pipeline read request, this cycle
//  pix_addr     in   ADDR_W  pixel read address
//  pix_gnt      out  1       pixel request accepted this cycle (combinational)
//  pix_rvalid   out  1       pix_rdata valid (cycle after pix_gnt)
//  pix_rdata    out  DATA_W  read data to pixel pipeline
//  cpu_req      in   1       CPU access request; held with addr/wdata/we stable until cpu_ack
//  cpu_we       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_ack      out  1       one-cycle completion pulse (cycle after CPU grant)
//  cpu_rdata    out  DATA_W  CPU read data, valid with cpu_ack on reads
//  mem_en       out  1       VRAM enable
//  mem_we       out  1       VRAM write enable
//  mem_addr     out  ADDR_W  VRAM address
//  mem_wdata    out  DATA_W  VRAM write data
//  mem_rdata    in   DATA_W  VRAM read data, 1-cycle latency after mem_en
// BEHAVIOUR
//  - Reset: all outputs 0, starve_cnt 0, cpu_ack/pix_rvalid pipeline cleared; in-flight access dropped, no ack issued.
//  - Per-cycle grant (combinational): one of NONE, PIX, CPU.
//      vga_blank=1: CPU if cpu_req & !ack_pending, else PIX if pix_req.
//      vga_blank=0: CPU if cpu_req & starve_cnt==STARVE_LIMIT, else PIX if pix_req, else CPU if cpu_req.
//  - ack_pending: set in the CPU grant cycle, cleared with cpu_ack; blocks re-granting the same held request.
//  - starve_cnt: +1 each cycle cpu_req & !ack_pending & grant!=CPU; cleared on CPU grant or cpu_req=0;
//    saturates at STARVE_LIMIT.
//  - Grant drives mem_* from the winner: mem_en=1, mem_we=cpu_we for CPU, 0 for PIX. NONE: mem_en=0, mem_we=0.
//  - Latency: pix_rvalid / cpu_ack registered, exactly 1 cycle after grant; rdata = mem_rdata routed by
//    registered grant tag. pix_rdata/cpu_rdata hold their last value otherwise.
//  - cpu_ack pulses for writes as well; cpu_rdata undefined-but-stable on writes (holds last read value).
//  - pix_gnt=0 with pix_req=1 (forced CPU slot): pixel side must retry next cycle; it is not queued here.
//  - vga_blank toggling mid-request: priority re-evaluated each cycle; granted accesses always complete.
//  - Simultaneous pix_req & cpu_req same address, write: CPU write completes; pixel read retries next cycle, sees new data.
// CONFIGURATION
//  VRAM_ARB_CPU_READ_EN defined: CPU reads go to VRAM as above.
//  Not defined: CPU reads are never granted to VRAM; cpu_ack pulses 1 cycle after cpu_req with cpu_rdata=0,
//  no starvation counting for reads; writes unchanged.
// STRUCTURE
//  gpu_pkg: VRAM_ADDR_W, VRAM data width, region base constants (TILE_BASE, ATTR_BASE, FONT_BASE, COLOR_BASE),
//  grant enum {GNT_NONE, GNT_PIX, GNT_CPU}.
//  Sub-module vram_arb_starve_counter: saturating counter with clear/inc/limit-hit flag.
// TESTING
//  1 Reset mid CPU grant (rst low cycle after grant) -> no cpu_ack, all outputs 0, counter 0.
//  2 vga_blank=1, pix_req & cpu_req (write 0x5A @0x0123) same cycle -> CPU granted, cpu_ack next cycle, readback 0x5A.
//  3 vga_blank=0, pix_req held, cpu_req read @0x0010 -> CPU granted on cycle 9 (STARVE_LIMIT=8), pix_gnt=0 that cycle only.
//  4 Pixel burst 3 reads @0x0000,0x0800,0x1800 -> pix_rvalid each following cycle with matching preloaded bytes.
//  5 cpu_req held after ack -> no second grant until cpu_req dropped for >=1 cycle.
//  6 Without VRAM_ARB_CPU_READ_EN: CPU read @0x0010 -> cpu_ack next cycle, cpu_rdata=0x00, mem_en never set by CPU.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU video RAM constants: address/data widths, region bases and the arbiter grant tag.
package gpu_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    // Four 2 KB regions sharing the single VRAM address space
    localparam logic [VRAM_ADDR_W-1:0] TILE_BASE  = 13'h0000;
    localparam logic [VRAM_ADDR_W-1:0] ATTR_BASE  = 13'h0800;
    localparam logic [VRAM_ADDR_W-1:0] FONT_BASE  = 13'h1000;
    localparam logic [VRAM_ADDR_W-1:0] COLOR_BASE = 13'h1800;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIX  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_e;

endpackage

// File: rtl/vram_arb_starve_counter.sv
// Saturating count of consecutive cycles a live CPU request has lost arbitration.
module vram_arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    localparam logic [7:0] LIM = 8'(LIMIT);

    logic [7:0] r_cnt;

    // Clear wins over increment; the count parks at the limit until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_hit = (r_cnt == LIM);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: pixel fetch wins in active video, CPU wins in blanking, starvation forces CPU through.
// Define VRAM_ARB_CPU_READ_EN to route CPU reads to VRAM; otherwise CPU reads complete locally with zero data.
module vram_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vga_blank,
    input  logic              i_pix_req,
    input  logic [ADDR_W-1:0] i_pix_addr,
    output logic              o_pix_gnt,
    output logic              o_pix_rvalid,
    output logic [DATA_W-1:0] o_pix_rdata,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    gnt_e              w_gnt;
    gnt_e              r_tag;
    logic              r_tag_we;
    logic              r_fake_ack;
    logic              r_ack_pending;
    logic [DATA_W-1:0] r_pix_hold;
    logic [DATA_W-1:0] r_cpu_hold;
    logic              w_cpu_live;
    logic              w_cpu_elig;
    logic              w_fake_rd;
    logic              w_starve_hit;
    logic              w_gnt_cpu;
    logic              w_cpu_rd_done;

    // A held request stays blocked after service until the CPU drops it for a cycle
    assign w_cpu_live = i_cpu_req & ~r_ack_pending;

`ifdef VRAM_ARB_CPU_READ_EN
    assign w_cpu_elig = w_cpu_live;
    assign w_fake_rd  = 1'b0;
`else
    assign w_cpu_elig = w_cpu_live & i_cpu_we;
    assign w_fake_rd  = w_cpu_live & ~i_cpu_we;
`endif

    // Per-cycle winner selection; nothing is granted while reset is asserted
    always_comb begin
        w_gnt = GNT_NONE;
        if (!rst) begin
            w_gnt = GNT_NONE;
        end else if (i_vga_blank) begin
            if (w_cpu_elig) begin
                w_gnt = GNT_CPU;
            end else if (i_pix_req) begin
                w_gnt = GNT_PIX;
            end else begin
                w_gnt = GNT_NONE;
            end
        end else begin
            if (w_cpu_elig && w_starve_hit) begin
                w_gnt = GNT_CPU;
            end else if (i_pix_req) begin
                w_gnt = GNT_PIX;
            end else if (w_cpu_elig) begin
                w_gnt = GNT_CPU;
            end else begin
                w_gnt = GNT_NONE;
            end
        end
    end

    assign w_gnt_cpu = (w_gnt == GNT_CPU);
    assign o_pix_gnt = (w_gnt == GNT_PIX);

    // Steer the VRAM port from the current winner
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = {ADDR_W{1'b0}};
        o_mem_wdata = {DATA_W{1'b0}};
        case (w_gnt)
            GNT_PIX: begin
                o_mem_en   = 1'b1;
                o_mem_addr = i_pix_addr;
            end
            GNT_CPU: begin
                o_mem_en    = 1'b1;
                o_mem_we    = i_cpu_we;
                o_mem_addr  = i_cpu_addr;
                o_mem_wdata = i_cpu_wdata;
            end
            default: begin
                o_mem_en = 1'b0;
            end
        endcase
    end

    vram_arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_clr (~i_cpu_req | w_gnt_cpu),
        .i_inc (w_cpu_elig & ~w_gnt_cpu),
        .o_hit (w_starve_hit)
    );

    // Read data arrives one cycle after the grant, so route it by the registered tag
    assign o_pix_rvalid  = (r_tag == GNT_PIX);
    assign o_cpu_ack     = (r_tag == GNT_CPU) | r_fake_ack;
    assign w_cpu_rd_done = (r_tag == GNT_CPU) & ~r_tag_we;
    assign o_pix_rdata   = o_pix_rvalid ? i_mem_rdata : r_pix_hold;
    assign o_cpu_rdata   = w_cpu_rd_done ? i_mem_rdata :
                           (r_fake_ack ? {DATA_W{1'b0}} : r_cpu_hold);

    // Grant tag, service tracking and read-data hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag         <= GNT_NONE;
            r_tag_we      <= 1'b0;
            r_fake_ack    <= 1'b0;
            r_ack_pending <= 1'b0;
            r_pix_hold    <= {DATA_W{1'b0}};
            r_cpu_hold    <= {DATA_W{1'b0}};
        end else begin
            r_tag      <= w_gnt;
            r_tag_we   <= w_gnt_cpu & i_cpu_we;
            r_fake_ack <= w_fake_rd;
            r_pix_hold <= o_pix_rdata;
            r_cpu_hold <= o_cpu_rdata;
            if (w_gnt_cpu || w_fake_rd) begin
                r_ack_pending <= 1'b1;
            end else if (!i_cpu_req) begin
                r_ack_pending <= 1'b0;
            end else begin
                r_ack_pending <= r_ack_pending;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_vram_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 8;
    localparam int LIM = 8;
`ifdef VRAM_ARB_CPU_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_blank, pix_req, cpu_req, cpu_we;
    logic [AW-1:0] pix_addr, cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          pix_gnt, pix_rvalid, cpu_ack, mem_en, mem_we;
    logic [DW-1:0] pix_rdata, cpu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = 8'h00;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .i_vga_blank(vga_blank),
        .i_pix_req(pix_req), .i_pix_addr(pix_addr), .o_pix_gnt(pix_gnt),
        .o_pix_rvalid(pix_rvalid), .o_pix_rdata(pix_rdata),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // VRAM macro stand-in with one cycle read latency
    logic [7:0] vram [0:8191];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
        end
    end

    // Behavioural reference state
    logic [7:0] shadow [0:8191];
    int         m_starve, m_tag, n_chk, n_fail, last_g;
    bit         m_pend, m_tag_we, m_fake, last_ack;
    logic [7:0] m_rd, e_pix_rd, e_cpu_rd;
    logic       obs_pix_gnt, obs_en, obs_we, obs_ack, obs_rvalid;
    logic [7:0] obs_pix_rd, obs_cpu_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_starve = 0; m_tag = 0; m_pend = 0; m_tag_we = 0; m_fake = 0;
        m_rd = 8'h00; e_pix_rd = 8'h00; e_cpu_rd = 8'h00;
    endtask

    task automatic drive_idle();
        vga_blank = 1'b0; pix_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        pix_addr = 13'h0; cpu_addr = 13'h0; cpu_wdata = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_gnt"}, {31'd0, pix_gnt}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, pix_rvalid}, 32'd0);
        chk({tag, "_pix_rdata"}, {24'd0, pix_rdata}, 32'd0);
        chk({tag, "_cpu_ack"}, {31'd0, cpu_ack}, 32'd0);
        chk({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    endtask

    // One clock cycle: inputs already driven; check against the model, then advance it
    task automatic cycle();
        bit live, can, fake;
        int g;
        #3;
        live = cpu_req && !m_pend;
        can  = live && (RD_EN || cpu_we);
        if (vga_blank) g = can ? 2 : (pix_req ? 1 : 0);
        else           g = (can && m_starve == LIM) ? 2 : (pix_req ? 1 : (can ? 2 : 0));
        if (m_tag == 1) e_pix_rd = m_rd;
        if (m_tag == 2 && !m_tag_we) e_cpu_rd = m_rd;
        if (m_fake) e_cpu_rd = 8'h00;
        chk("pix_gnt", {31'd0, pix_gnt}, {31'd0, g == 1});
        chk("mem_en", {31'd0, mem_en}, {31'd0, g != 0});
        chk("mem_we", {31'd0, mem_we}, {31'd0, g == 2 && cpu_we});
        if (g == 1) chk("mem_addr_pix", {19'd0, mem_addr}, {19'd0, pix_addr});
        if (g == 2) chk("mem_addr_cpu", {19'd0, mem_addr}, {19'd0, cpu_addr});
        if (g == 2 && cpu_we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, cpu_wdata});
        chk("pix_rvalid", {31'd0, pix_rvalid}, {31'd0, m_tag == 1});
        chk("cpu_ack", {31'd0, cpu_ack}, {31'd0, m_tag == 2 || m_fake});
        chk("pix_rdata", {24'd0, pix_rdata}, {24'd0, e_pix_rd});
        chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e_cpu_rd});
        obs_pix_gnt = pix_gnt; obs_en = mem_en; obs_we = mem_we; obs_ack = cpu_ack;
        obs_rvalid = pix_rvalid; obs_pix_rd = pix_rdata; obs_cpu_rd = cpu_rdata;
        last_g = g; last_ack = (m_tag == 2) || m_fake;
        fake = live && !RD_EN && !cpu_we;
        m_rd = (g == 1) ? shadow[pix_addr] : shadow[cpu_addr];
        if (g == 2 && cpu_we) shadow[cpu_addr] = cpu_wdata;
        m_tag = g; m_tag_we = (g == 2) && cpu_we; m_fake = fake;
        if (g == 2 || fake) m_pend = 1'b1;
        else if (!cpu_req)  m_pend = 1'b0;
        if (!cpu_req || g == 2) m_starve = 0;
        else if (can && m_starve < LIM) m_starve++;
        @(posedge clk); #1;
    endtask

    int  acks, found, extra;
    bit  acked;
    logic [12:0] t4_addr [0:2];
    logic [7:0]  t4_data [0:2];

    initial begin
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 8192; i++) begin
            vram[i] = 8'($urandom);
            shadow[i] = vram[i];
        end
        t4_addr[0] = 13'h0000; t4_addr[1] = 13'h0800; t4_addr[2] = 13'h1800;
        t4_data[0] = 8'h11;    t4_data[1] = 8'h22;    t4_data[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            vram[t4_addr[i]] = t4_data[i];
            shadow[t4_addr[i]] = t4_data[i];
        end

        rst = 1'b0; drive_idle(); model_reset();
        repeat (3) @(posedge clk);
        #1; check_all_zero("rst");
        rst = 1'b1;

        // 1: reset asserted the cycle after a CPU grant drops the ack
        vga_blank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'hC3;
        cycle();
        chk("t1_gnt", {31'd0, obs_en}, 32'd1);
        rst = 1'b0; #1;
        check_all_zero("t1");
        drive_idle(); model_reset();
        @(posedge clk); #1; rst = 1'b1;

        // 2: blanking collision, CPU write wins and the retried pixel read sees new data
        vga_blank = 1'b1; pix_req = 1'b1; pix_addr = 13'h0123;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_wdata = 8'h5A;
        cycle();
        chk("t2_pix_gnt", {31'd0, obs_pix_gnt}, 32'd0);
        chk("t2_mem_we", {31'd0, obs_we}, 32'd1);
        cycle();
        chk("t2_ack", {31'd0, obs_ack}, 32'd1);
        chk("t2_pix_retry_gnt", {31'd0, obs_pix_gnt}, 32'd1);
        cpu_req = 1'b0; pix_req = 1'b0;
        cycle();
        chk("t2_readback", {24'd0, obs_pix_rd}, 32'h5A);

        // Charge the starvation counter, then reset to prove it clears
        drive_idle(); pix_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300;
        repeat (4) cycle();
        rst = 1'b0; drive_idle(); model_reset();
        @(posedge clk); #1; rst = 1'b1;

        // 3: active video with pixel pressure, CPU forced through on cycle 9
        vga_blank = 1'b0; pix_req = 1'b1; pix_addr = 13'h0040;
        cpu_req = 1'b1; cpu_we = !RD_EN; cpu_addr = 13'h0010; cpu_wdata = 8'h77;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (found == 0 && last_g == 2) found = i;
        end
        chk("t3_starve_cycle", found, 32'd9);
        drive_idle(); cycle();

        // 4: pixel burst across regions
        for (int i = 0; i < 4; i++) begin
            pix_req = (i < 3); pix_addr = (i < 3) ? t4_addr[i] : 13'h0;
            cycle();
            if (i > 0) begin
                chk("t4_rvalid", {31'd0, obs_rvalid}, 32'd1);
                chk("t4_rdata", {24'd0, obs_pix_rd}, {24'd0, t4_data[i-1]});
            end
        end

        // 5: held request is served once until dropped
        drive_idle(); vga_blank = 1'b1; cpu_req = 1'b1; cpu_addr = 13'h0040;
        acks = 0;
        repeat (5) begin cycle(); acks += int'(last_ack); end
        chk("t5_held_acks", acks, 32'd1);
        cpu_req = 1'b0; cycle(); cpu_req = 1'b1;
        acks = 0;
        repeat (3) begin cycle(); acks += int'(last_ack); end
        chk("t5_rearm_acks", acks, 32'd1);
        drive_idle(); cycle();

        // 6: CPU read path per build configuration
        vga_blank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
        cpu_addr = RD_EN ? 13'h0123 : 13'h0010;
        cycle();
        chk("t6_mem_en", {31'd0, obs_en}, {31'd0, RD_EN});
        cycle();
        chk("t6_ack", {31'd0, obs_ack}, 32'd1);
        chk("t6_rdata", {24'd0, obs_cpu_rd}, RD_EN ? 32'h5A : 32'h00);
        drive_idle(); cycle();

        // Randomized traffic on a small address window to force collisions
        acked = 1'b0; extra = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) vga_blank = ~vga_blank;
            pix_req = vga_blank ? ($urandom_range(1) == 1) : ($urandom_range(7) != 0);
            pix_addr = 13'($urandom_range(31));
            if (!cpu_req) begin
                if ($urandom_range(2) == 0) begin
                    cpu_req = 1'b1; cpu_we = ($urandom_range(1) == 1);
                    cpu_addr = 13'($urandom_range(31)); cpu_wdata = 8'($urandom);
                    acked = 1'b0; extra = $urandom_range(2);
                end
            end else if (acked) begin
                if (extra == 0) cpu_req = 1'b0;
                else extra--;
            end
            cycle();
            if (last_ack) acked = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
